// File: rtl/imem_param.sv
// Instruction memory with a power-on clear sweep, a streamed program-load
// port and a registered single-cycle fetch port.
module imem_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_req,
  input  logic              stall,
  output logic [DATA_W-1:0] inst_out,
  output logic              inst_valid,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_inst;
  logic              r_valid;
  logic              r_done;

  logic w_accept, w_clr_end, w_start;

  assign w_accept  = (r_state == LOAD) && ld_valid;
  assign w_clr_end = (r_state == CLEAR) && (r_cnt == ADDR_W'(DEPTH - 1));
  assign w_start   = (r_state == IDLE) && ld_start;

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= CLEAR;
    else      r_state <= w_next;
  end

  // Next-state: clear -> idle after the last address, idle <-> load.
  always_comb begin
    w_next = r_state;
    case (r_state)
      CLEAR:   if (w_clr_end) w_next = IDLE;
      IDLE:    if (ld_start) w_next = LOAD;
      LOAD:    if (w_accept && ld_last) w_next = IDLE;
      default: w_next = CLEAR;
    endcase
  end

  // Shared address counter: sweep index in CLEAR, write pointer in LOAD.
  // Natural ADDR_W overflow gives the modulo-DEPTH wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          r_cnt <= '0;
    else if (r_state == CLEAR)         r_cnt <= r_cnt + 1'b1;
    else if (w_start)                  r_cnt <= ld_base;
    else if (w_accept)                 r_cnt <= r_cnt + 1'b1;
  end

  // Storage array: not reset, zeroed by the clear sweep instead.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) r_mem[r_cnt] <= '0;
    else if (w_accept)    r_mem[r_cnt] <= ld_data;
  end

  // Fetch port: a load request beats a fetch; stall freezes the output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inst  <= '0;
      r_valid <= 1'b0;
    end else if (r_state != IDLE || ld_start) begin
      r_valid <= 1'b0;
    end else if (!stall) begin
      if (fetch_req) begin
        r_inst  <= r_mem[pc];
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  // Load-complete pulse, one cycle after the final word is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_done <= 1'b0;
    else      r_done <= w_accept && ld_last;
  end

  assign inst_out   = r_inst;
  assign inst_valid = r_valid;
  assign ld_done    = r_done;
  assign ld_ready   = (r_state == LOAD);
  assign busy       = (r_state == CLEAR) || (r_state == LOAD);

endmodule

// File: doc/imem_param.md
IMEM_PARAM -- requirements
Module: imem_param

Interface
REQ-001 Parameter DATA_W, default 8: instruction word width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W words.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 pc  input  ADDR_W  fetch address.
REQ-006 fetch_req  input  1  fetch request, sampled on the clock edge.
REQ-007 stall  input  1  pipeline stall; holds the fetch output.
REQ-008 inst_out  output  DATA_W  registered instruction word.
REQ-009 inst_valid  output  1  inst_out holds a word fetched in response to a request.
REQ-010 ld_start  input  1  begin a program load at ld_base.
REQ-011 ld_base  input  ADDR_W  first load address, sampled with ld_start.
REQ-012 ld_valid  input  1  ld_data is valid.
REQ-013 ld_data  input  DATA_W  word to write.
REQ-014 ld_last  input  1  the current ld_data is the final word of the load.
REQ-015 ld_ready  output  1  block accepts ld_data this cycle.
REQ-016 ld_done  output  1  one-cycle pulse; load complete.
REQ-017 busy  output  1  block is in CLEAR or LOAD; fetches are ignored.

Function
REQ-018 Storage: DEPTH x DATA_W register array, written only by the CLEAR sweep or the LOAD handshake.
REQ-019 FSM states: CLEAR, IDLE, LOAD; the state register resets to CLEAR.
REQ-020 CLEAR writes 0 to mem[cnt], with cnt running 0..DEPTH-1, one word per cycle.
REQ-021 CLEAR exits to IDLE on the cycle that writes DEPTH-1, so CLEAR lasts exactly DEPTH cycles after reset release.
REQ-022 ld_start is ignored in CLEAR and in LOAD.
REQ-023 IDLE, fetch accepted (fetch_req=1, stall=0, ld_start=0): next edge sets inst_out=mem[pc] and inst_valid=1; latency is 1 cycle.
REQ-024 IDLE with stall=1: inst_out and inst_valid hold regardless of fetch_req or pc.
REQ-025 IDLE with fetch_req=0, stall=0: inst_valid goes to 0 and inst_out holds.
REQ-026 IDLE with ld_start=1: the load wins over any simultaneous fetch.
REQ-027 On that ld_start edge: go to LOAD, cnt=ld_base, inst_valid=0.
REQ-028 ld_ready=1 exactly when the state is LOAD.
REQ-029 Accept condition: ld_valid and ld_ready both 1.
REQ-030 On accept: mem[cnt]=ld_data, then cnt=cnt+1 modulo DEPTH, so DEPTH-1 wraps to 0.
REQ-031 An accept with ld_last=1 returns the FSM to IDLE and pulses ld_done on the following cycle.
REQ-032 A load longer than DEPTH words overwrites earlier words in wrap order; no error is flagged.
REQ-033 In CLEAR and LOAD: fetch_req is ignored, inst_valid=0, and inst_out holds its last value.
REQ-034 busy=1 exactly when the state is CLEAR or LOAD.
REQ-035 ld_ready is registered, derived from the state register only.

Reset
REQ-036 rst=0 asynchronously forces: state=CLEAR, cnt=0, inst_out=0, inst_valid=0, ld_done=0, busy=1.
REQ-037 Reset has no asynchronous effect on mem contents; the CLEAR sweep zeroes them.
REQ-038 Reset asserted mid-LOAD or mid-CLEAR aborts the operation; no ld_done pulse is issued.
REQ-039 After reset release, the CLEAR sweep restarts from address 0.
REQ-040 Reset release is synchronised by the integrator; the block takes no action on the release edge other than starting CLEAR.

Verification
REQ-041 Reset release -> busy=1 for 32 cycles (defaults), then 0; fetch pc=7 -> inst_out=0x00, inst_valid=1 one cycle later.
REQ-042 Load at ld_base=0 with words 0x0B,0x49,0x12 (last on 0x12) -> ld_done pulse; fetches of pc=0,1,2 -> 0x0B,0x49,0x12 at 1-cycle latency.
REQ-043 Load at ld_base=30 with words 0xA1,0xA2,0xA3 -> mem[30]=0xA1, mem[31]=0xA2, mem[0]=0xA3, confirming wrap.
REQ-044 Fetch pc=1 then stall=1 for 3 cycles while pc changes to 2 -> inst_out stays 0x49, inst_valid stays 1; after stall=0, pc=2 -> 0x12.
REQ-045 ld_start and fetch_req in the same IDLE cycle -> inst_valid=0 next cycle and ld_ready=1; ld_valid held at 0 for 5 cycles -> no writes occur.
REQ-046 rst=0 pulsed during the second load word -> no ld_done; CLEAR re-runs; all words read 0x00 afterwards.
